// File: rtl/display_char_buffer.sv
// Circular character store feeding NUM_CH registered display channels.
// The display window is either stepped manually by scroll or tracks the newest writes.
module display_char_buffer #(
    parameter int               WIDTH  = 4,
    parameter int               DEPTH  = 16,
    parameter int               NUM_CH = 4,
    parameter logic [WIDTH-1:0] BLANK  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      clear,
    input  logic                      follow,
    input  logic                      scroll,
    output logic [NUM_CH*WIDTH-1:0]   char_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH)-1:0]  wr_ptr_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int OUT_W  = NUM_CH * WIDTH;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] CH_OFFSET  = ADDR_W'(NUM_CH);

    // Channel i shows value i after reset, i.e. the identity pattern of mem.
    function automatic logic [OUT_W-1:0] identity_window();
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'(i);
        end
        return r;
    endfunction

    localparam logic [OUT_W-1:0] RESET_WINDOW = identity_window();

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_eff;
    logic [OUT_W-1:0]  window;

    // Write port: wr_valid is a strobe with an implicit, always-high ready.
    // Every cycle it is high one character is taken; nothing is ever stalled,
    // so a full buffer silently overwrites its oldest entry.
    logic do_write;
    logic do_scroll;

    always_comb begin
        do_write  = wr_valid && !clear;
        do_scroll = scroll && !follow && !clear;
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= BLANK;
            end
        end else if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Write pointer and fill count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_write && (count != FULL_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign wr_ptr_o = wr_ptr;

    // ------------------------------------------------------------------
    // Window base: the manual base is frozen while following so that
    // manual scrolling resumes from where it was left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base <= '0;
        end else if (clear) begin
            base <= '0;
        end else if (do_scroll) begin
            base <= base + 1'b1;
        end
    end

    always_comb begin
        base_eff = follow ? (wr_ptr - CH_OFFSET) : base;
    end

    // Window addresses wrap naturally through ADDR_W-bit arithmetic.
    always_comb begin
        window = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            window[i*WIDTH +: WIDTH] = mem[base_eff + ADDR_W'(i)];
        end
    end

    // ------------------------------------------------------------------
    // Registered channel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char_out <= RESET_WINDOW;
        end else begin
            char_out <= window;
        end
    end

endmodule

// File: tb/tb_display_char_buffer.sv
// Bench for display_char_buffer: per-cycle expected outputs from a reference
// model are queued by the driver and checked by an independent monitor.
module tb_display_char_buffer;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    localparam int CH_W   = NUM_CH * WIDTH;
    localparam int W      = CH_W + CNT_W + ADDR_W;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_valid = 1'b0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              clear = 1'b0;
    logic              follow = 1'b0;
    logic              scroll = 1'b0;
    logic [CH_W-1:0]   char_out;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] wr_ptr_o;

    always #5 clk = ~clk;

    display_char_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .clear    (clear),
        .follow   (follow),
        .scroll   (scroll),
        .char_out (char_out),
        .count    (count),
        .wr_ptr_o (wr_ptr_o)
    );

    // ------------------------------------------------------------------
    // Reference model: plain integer state with modulo arithmetic
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_wp;
    int               m_base;
    int               m_cnt;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = WIDTH'(i % 16);
        m_wp   = 0;
        m_base = 0;
        m_cnt  = 0;
    endtask

    function automatic logic [CH_W-1:0] model_window(input logic fol);
        logic [CH_W-1:0] r;
        int b;
        b = fol ? ((m_wp - NUM_CH + 2 * DEPTH) % DEPTH) : m_base;
        r = '0;
        for (int ch = 0; ch < NUM_CH; ch++) r[ch*WIDTH +: WIDTH] = m_mem[(b + ch) % DEPTH];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic do_cycle(input logic wv, input logic [WIDTH-1:0] wd,
                            input logic clr, input logic fol, input logic scr);
        logic [CH_W-1:0] e_char;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        clear    = clr;
        follow   = fol;
        scroll   = scr;
        e_char = model_window(fol);
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_wp = 0; m_base = 0; m_cnt = 0;
        end else begin
            if (wv) begin
                m_mem[m_wp] = wd;
                m_wp  = (m_wp + 1) % DEPTH;
                m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
            end
            if (scr && !fol) m_base = (m_base + 1) % DEPTH;
        end
        exp_q.push_back({e_char, CNT_W'(m_cnt), ADDR_W'(m_wp)});
    endtask

    task automatic idle(input logic fol);
        do_cycle(1'b0, '0, 1'b0, fol, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_field("char_out", 32'(char_out), 32'(e[W-1 -: CH_W]));
            check_field("count",    32'(count),    32'(e[ADDR_W +: CNT_W]));
            check_field("wr_ptr_o", 32'(wr_ptr_o), 32'(e[ADDR_W-1:0]));
        end
    end

    task automatic check_now(input string name, input logic [CH_W-1:0] e_char,
                             input int e_cnt, input int e_wp);
        @(posedge clk);
        #2;
        check_field({name, "_char"}, 32'(char_out), 32'(e_char));
        check_field({name, "_count"}, 32'(count), e_cnt);
        check_field({name, "_wp"}, 32'(wr_ptr_o), e_wp);
    endtask

    // Reset is dropped between edges and checked before the next edge.
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        wr_valid = 1'b0; clear = 1'b0; scroll = 1'b0; follow = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_field({name, "_char"}, 32'(char_out), 32'h3210);
        check_field({name, "_count"}, 32'(count), 0);
        check_field({name, "_wp"}, 32'(wr_ptr_o), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic fol;
        model_reset();
        async_reset("reset");

        // Identity contents visible through every manual window.
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Manual write A,B,C,D.
        async_reset("reset2");
        do_cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check_now("manual", 16'hDCBA, 4, 4);

        // Wrap and follow.
        async_reset("reset3");
        for (int i = 0; i < 16; i++) do_cycle(1'b1, WIDTH'(i), 1'b0, 1'b1, 1'b0);
        do_cycle(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check_now("follow_wrap", 16'h5FED, 16, 1);

        // Scroll wrap, then scroll ignored in follow mode.
        async_reset("reset4");
        for (int i = 0; i < 14; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check_now("scroll_wrap", 16'h10FE, 0, 0);
        do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        check_now("scroll_follow", 16'h10FE, 0, 0);

        // Clear beats write and scroll; sweep all windows for stray 0x7.
        do_cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        check_now("clear", 16'h0000, 0, 0);
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Async reset during a follow-mode burst; writes resume at 0.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
        async_reset("async_mid");
        for (int i = 0; i < 3; i++) do_cycle(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
        idle(1'b1);

        // Randomized traffic.
        fol = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) fol = ~fol;
            do_cycle($urandom_range(0, 9) < 7, WIDTH'($urandom_range(0, 15)),
                     $urandom_range(0, 49) == 0, fol, $urandom_range(0, 9) < 3);
        end
        idle(fol);

        @(posedge clk);
        #3;
        check_field("drain", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
